// File: rtl/game_logic_nxn_if.sv
// Move-engine handshake bundle: request side (board, direction, goal, start)
// and result side (new board, status, score).
interface game_logic_nxn_if #(
  parameter int N       = 4,
  parameter int VAL_W   = 12,
  parameter int SCORE_W = 16
);
  logic                              start;
  logic [3:0]                        goal;
  logic [3:0]                        direction;
  logic [N-1:0][N-1:0][VAL_W-1:0]    matrix;
  logic [N-1:0][N-1:0][VAL_W-1:0]    matrix_D;
  logic [1:0]                        wl;
  logic                              busy;
  logic                              done;
  logic                              moved;
  logic [SCORE_W-1:0]                score_add;

  modport master (
    output start, goal, direction, matrix,
    input  matrix_D, wl, busy, done, moved, score_add
  );

  modport slave (
    input  start, goal, direction, matrix,
    output matrix_D, wl, busy, done, moved, score_add
  );
endinterface

// File: rtl/game_logic_nxn.sv
// NxN 2048 move engine: slides/merges one line per clock, then
// evaluates win/lose and publishes board, moved flag and score.
module game_logic_nxn #(
  parameter int N       = 4,
  parameter int VAL_W   = 12,
  parameter int SCORE_W = 16
) (
  input logic              clk,
  input logic              rst,
  game_logic_nxn_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam int AW = (SCORE_W > VAL_W ? SCORE_W : VAL_W);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  typedef logic [N-1:0][N-1:0][VAL_W-1:0] board_t;
  typedef logic [N-1:0][VAL_W-1:0]        line_t;
  typedef enum logic [1:0] {IDLE, LINE, EVAL, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  board_t             mat_q, mat_d;
  board_t             res_q, res_d;
  logic [3:0]         goal_q, goal_d;
  logic [1:0]         sel_q, sel_d;
  logic               pass_q, pass_d;
  logic [SCORE_W-1:0] score_q, score_d;
  board_t             out_q, out_d;
  logic [1:0]         wl_q, wl_d;
  logic               moved_q, moved_d;
  logic [SCORE_W-1:0] sadd_q, sadd_d;

  line_t              line_in, cmp, mrg;
  logic [SCORE_W-1:0] line_sc;
  logic               win, lose, has_zero, has_pair;
  logic               onehot;
  logic [1:0]         sel_new;

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [AW-1:0]      b
  );
    logic [AW:0] s;
    s = {1'b0, AW'(a)} + {1'b0, b};
    return (s > (AW+1)'(SMAX)) ? SMAX : s[SCORE_W-1:0];
  endfunction

  // line element 0 is always the lead end
  always_comb begin
    line_in = '0;
    for (int i = 0; i < N; i++) begin
      case (sel_q)
        2'd0:    line_in[i] = res_q[i][cnt_q];
        2'd1:    line_in[i] = res_q[N-1-i][cnt_q];
        2'd2:    line_in[i] = res_q[cnt_q][i];
        default: line_in[i] = res_q[cnt_q][N-1-i];
      endcase
    end
  end

  always_comb begin
    int k;
    int o;
    int nx;
    logic skip;
    cmp     = '0;
    mrg     = '0;
    line_sc = '0;
    k       = 0;
    o       = 0;
    skip    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (line_in[i] != '0) begin
        cmp[k] = line_in[i];
        k      = k + 1;
      end
    end
    // top-bit tiles are saturated and never merge
    for (int i = 0; i < N; i++) begin
      nx = (i < N-1) ? i + 1 : i;
      if (skip) begin
        skip = 1'b0;
      end else if (i < N-1 && cmp[i] != '0 &&
                   cmp[i] == cmp[nx] && !cmp[i][VAL_W-1]) begin
        mrg[o]  = cmp[i] << 1;
        line_sc = sat_add(line_sc, AW'(cmp[i] << 1));
        o       = o + 1;
        skip    = 1'b1;
      end else begin
        mrg[o] = cmp[i];
        o      = o + 1;
      end
    end
  end

  always_comb begin
    has_zero = 1'b0;
    has_pair = 1'b0;
    win      = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (res_q[r][c] == '0) has_zero = 1'b1;
        if (32'(res_q[r][c]) >= (32'd1 << goal_q)) win = 1'b1;
      end
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N-1; c++)
        if (res_q[r][c] == res_q[r][c+1]) has_pair = 1'b1;
    for (int r = 0; r < N-1; r++)
      for (int c = 0; c < N; c++)
        if (res_q[r][c] == res_q[r+1][c]) has_pair = 1'b1;
    lose = !win && !has_zero && !has_pair;
  end

  always_comb begin
    onehot  = 1'b1;
    sel_new = 2'd0;
    case (bus.direction)
      4'b0001: sel_new = 2'd0;
      4'b0010: sel_new = 2'd1;
      4'b0100: sel_new = 2'd2;
      4'b1000: sel_new = 2'd3;
      default: onehot  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    res_d   = res_q;
    goal_d  = goal_q;
    sel_d   = sel_q;
    pass_d  = pass_q;
    score_d = score_q;
    out_d   = out_q;
    wl_d    = wl_q;
    moved_d = moved_q;
    sadd_d  = sadd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mat_d   = bus.matrix;
          res_d   = bus.matrix;
          goal_d  = bus.goal;
          sel_d   = sel_new;
          pass_d  = !onehot;
          cnt_d   = '0;
          score_d = '0;
          state_d = LINE;
        end
      end
      LINE: begin
        if (!pass_q) begin
          for (int i = 0; i < N; i++) begin
            case (sel_q)
              2'd0:    res_d[i][cnt_q]     = mrg[i];
              2'd1:    res_d[N-1-i][cnt_q] = mrg[i];
              2'd2:    res_d[cnt_q][i]     = mrg[i];
              default: res_d[cnt_q][N-1-i] = mrg[i];
            endcase
          end
          score_d = sat_add(score_q, AW'(line_sc));
        end
        if (cnt_q == CW'(N-1)) state_d = EVAL;
        else cnt_d = cnt_q + CW'(1);
      end
      EVAL: begin
        out_d   = res_q;
        wl_d    = {win, lose};
        moved_d = (res_q != mat_q);
        sadd_d  = score_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mat_q   <= '0;
      res_q   <= '0;
      goal_q  <= '0;
      sel_q   <= '0;
      pass_q  <= 1'b0;
      score_q <= '0;
      out_q   <= '0;
      wl_q    <= '0;
      moved_q <= 1'b0;
      sadd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      res_q   <= res_d;
      goal_q  <= goal_d;
      sel_q   <= sel_d;
      pass_q  <= pass_d;
      score_q <= score_d;
      out_q   <= out_d;
      wl_q    <= wl_d;
      moved_q <= moved_d;
      sadd_q  <= sadd_d;
    end
  end

  assign bus.matrix_D  = out_q;
  assign bus.wl        = wl_q;
  assign bus.moved     = moved_q;
  assign bus.score_add = sadd_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
endmodule

// File: doc/game_logic_nxn.md
Name: game_logic_nxn

Overview:
Parametrised successor of the 2048 move engine. It takes an N×N board of tile values plus a one-hot direction. It slides and merges the board one line per clock, then reports the new board, a moved flag, the score gained and the win/lose status. It sits between the input/direction controller and the board register/tile spawner. Unlike the fixed 4×4 engine, it adds a start/busy/done handshake, score output, a moved flag and merge saturation.

Parameters:
N, 4, board side length (rows = columns = N, N ≥ 2)
VAL_W, 12, tile value width; tile holds the literal value (0 = empty, 2, 4, 8, …)
SCORE_W, 16, width of score_add

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
start  in  1  one-cycle request to execute a move; ignored while busy
goal  in  4  win exponent; win when any tile ≥ 2^goal
direction  in  4  one-hot: [0]=up, [1]=down, [2]=left, [3]=right
matrix  in  VAL_W × [N][N]  current board, [r][c], r=0 top, c=0 left; sampled at start
matrix_D  out  VAL_W × [N][N]  resulting board, registered
wl  out  2  [1]=win, [0]=lose; registered
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse; outputs valid from this cycle
moved  out  1  1 if matrix_D differs from the sampled matrix
score_add  out  SCORE_W  sum of all values created by merges in this move

Behaviour:
- Reset: state IDLE; matrix_D all 0; wl=00; busy, done and moved = 0; score_add=0; line counter 0.
- FSM: IDLE → LINE → EVAL → DONE → IDLE.
- IDLE, start=1:
  - Latch matrix, goal and direction.
  - Direction one-hot: go to LINE, counter=0.
  - Direction not one-hot (incl. 0000): go to LINE with pass-through (no slide/merge).
- LINE: one line per cycle, counter 0..N-1.
  - Line = column for up/down, row for left/right.
  - Lead end = r=0 (up), r=N-1 (down), c=0 (left), c=N-1 (right).
  - Per line:
    - compress non-zero tiles toward the lead end, keeping order;
    - merge equal adjacent pairs starting from the lead end; each tile merges at most once per move;
    - compress again.
  - Example, left: {2,2,2,0} → {4,2,0,0}; {2,2,4,4} → {4,8,0,0}.
  - Saturation: two tiles equal to 2^(VAL_W-1) do not merge (no overflow).
  - Merged values accumulate into score_add, which saturates at 2^SCORE_W-1.
  - After counter=N-1, go to EVAL.
- EVAL: one cycle on the result board.
  - win = any tile ≥ 2^goal.
  - lose = no zero tile and no horizontally or vertically adjacent equal pair (saturated max pairs count as equal).
  - win has priority: if win, lose=0.
  - moved = result ≠ latched board.
- DONE: done=1 for one cycle; busy falls in the same cycle; return to IDLE.
  - matrix_D, wl, moved and score_add are updated at the DONE edge and held until the next DONE or rst.
- Latency: start accepted in cycle 0; busy in cycles 1..N+2; done in cycle N+2 (6 for N=4). Same latency for the illegal-direction pass-through.
- While busy:
  - start is ignored;
  - changes on matrix, goal and direction are ignored (latched copies are used).
- rst during any state: abort immediately to reset values; no done pulse.
- start asserted in the DONE cycle: ignored; a new start is accepted only from IDLE.

Test Plan:
1. N=4, left; row0={2,2,4,4}, row1={2,2,2,0}, others 0 → row0={4,8,0,0}, row1={4,2,0,0}; score_add=16; moved=1; wl=00; done exactly 6 cycles after start.
2. Right, row0={0,4,4,4}; up, column0 top→bottom {2,0,2,4} → row0={0,0,4,8}, score 8; column0={4,4,0,0}, score 4; moved=1 both.
3. goal=6, down, column3 top→bottom {32,0,0,32} → column3={0,0,0,64}; wl=10; score_add=64.
4. Full 2/4 checkerboard, left → matrix_D identical to input; moved=0; score_add=0; wl=01. Repeat with goal=1 → wl=10 (win priority).
5. VAL_W=12, left, row0={2048,2048,0,0} → row0 unchanged; moved=0; score_add=0. Direction=0011 on any board → pass-through, moved=0, done at cycle 6.
6. Reset and handshake:
   - rst in cycle 3 of a move → no done pulse; all outputs 0 next cycle.
   - A second start while busy → ignored; exactly one done pulse.
   - matrix changed mid-move → result reflects the latched board.
